read_port_arbiter: RTL and testbench

READ_PORT_ARBITER -- requirements
Module: read_port_arbiter

---
 rtl/read_port_arbiter_pkg.sv | 13 +
 rtl/read_port_arbiter_rr_pick2.sv | 12 +
 rtl/read_port_arbiter.sv | 81 ++++++++
 tb/tb_read_port_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/read_port_arbiter_pkg.sv
// Shared types and default widths for the two-requester register-file read arbiter.
package read_port_arbiter_pkg;

    localparam int DEF_WORD_SIZE  = 5;
    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/read_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: the pointer breaks ties, a lone request always wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       pointer,
    output logic       winner,
    output logic       any
);

    assign any    = |req;
    assign winner = (&req) ? pointer : req[1];

endmodule

// File: rtl/read_port_arbiter.sv
// Arbitrates two read requesters onto one register-file read port (IDLE -> ISSUE -> RESP).
module read_port_arbiter
    import read_port_arbiter_pkg::*;
#(
    parameter int WORD_SIZE  = DEF_WORD_SIZE,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic [WORD_SIZE-1:0]  addr0,
    input  logic                  req1,
    input  logic [WORD_SIZE-1:0]  addr1,
    output logic                  mux_select,
    output logic                  rf_rd_en,
    input  logic [DATA_WIDTH-1:0] rf_rdata,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy
);

    state_t state, state_nxt;
    logic   ptr;
    logic   winner;
    logic   any;

    // Addresses only feed the external mux; they are listed here to keep the interface whole.
    logic   unused_addr;
    assign unused_addr = ^{addr0, addr1};

    rr_pick2 u_pick (
        .req    ({req1, req0}),
        .pointer(ptr),
        .winner (winner),
        .any    (any)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any) state_nxt = ISSUE;
            ISSUE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            mux_select <= 1'b0;
            rdata      <= '0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
        end else begin
            state   <= state_nxt;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            // mux_select doubles as the latched winner for the rest of the transaction
            if (state == IDLE && any) begin
                mux_select <= winner;
                ptr        <= ~winner;
            end
            if (state == RESP) begin
                rdata   <= rf_rdata;
                rvalid0 <= ~mux_select;
                rvalid1 <= mux_select;
            end
        end
    end

    assign rf_rd_en = (state == ISSUE);
    assign gnt0     = rf_rd_en & ~mux_select;
    assign gnt1     = rf_rd_en & mux_select;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_read_port_arbiter.sv
// Randomized and directed checks of read_port_arbiter against a transaction-level model.
module tb_read_port_arbiter;

    localparam int WS = 5;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1;
    logic [WS-1:0] addr0, addr1;
    logic          mux_select, rf_rd_en;
    logic [DW-1:0] rf_rdata = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [DW-1:0] rdata;

    int n_chk = 0;
    int n_err = 0;

    logic [DW-1:0] mem [32];

    // model: where the transaction is, who won, what it will return
    int            m_phase;
    logic          m_win, m_ptr, m_msel, m_rv, m_rvw;
    logic [WS-1:0] m_addr;
    logic [DW-1:0] m_rdata;

    logic          g_seen [$];

    always #5 clk = ~clk;

    read_port_arbiter #(.WORD_SIZE(WS), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .addr0     (addr0),
        .req1      (req1),
        .addr1     (addr1),
        .mux_select(mux_select),
        .rf_rd_en  (rf_rd_en),
        .rf_rdata  (rf_rdata),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .busy      (busy)
    );

    // register file: synchronous read through the external address mux
    always @(posedge clk)
        if (rf_rd_en) rf_rdata <= mem[mux_select ? addr1 : addr0];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_win = 0; m_ptr = 0; m_msel = 0;
        m_rv = 0; m_rvw = 0; m_addr = '0; m_rdata = '0;
    endtask

    task automatic model_step();
        if (!rst_n) begin
            model_reset();
        end else begin
            m_rv = 0;
            case (m_phase)
                0: if (req0 || req1) begin
                    m_win   = (req0 && req1) ? m_ptr : req1;
                    m_ptr   = !m_win;
                    m_msel  = m_win;
                    m_addr  = m_win ? addr1 : addr0;
                    m_phase = 1;
                end
                1: m_phase = 2;
                default: begin
                    m_rdata = mem[m_addr];
                    m_rv    = 1;
                    m_rvw   = m_win;
                    m_phase = 0;
                end
            endcase
        end
    endtask

    task automatic check_all();
        chk("mux_select", 32'(mux_select), 32'(m_msel));
        chk("rf_rd_en",   32'(rf_rd_en),   32'(m_phase == 1));
        chk("gnt0",       32'(gnt0),       32'(m_phase == 1 && !m_win));
        chk("gnt1",       32'(gnt1),       32'(m_phase == 1 && m_win));
        chk("rvalid0",    32'(rvalid0),    32'(m_rv && !m_rvw));
        chk("rvalid1",    32'(rvalid1),    32'(m_rv && m_rvw));
        chk("rdata",      32'(rdata),      32'(m_rdata));
        chk("busy",       32'(busy),       32'(m_phase != 0));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1 model_reset();
        check_all();
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req0 = 0; req1 = 0; addr0 = '0; addr1 = '0;
        for (int i = 0; i < 32; i++) mem[i] = DW'($urandom);
        mem[3] = 8'hA5; mem[9] = 8'h5A; mem[17] = 8'h3C;
        model_reset();
        @(negedge clk);
        check_all();
        cycle();
        rst_n = 1'b1;

        // lone requester 0
        req0 = 1; addr0 = 5'd3;
        cycle();
        chk("t36_gnt0", 32'(gnt0), 32'd1);
        req0 = 0;
        cycle();
        cycle();
        chk("t36_rvalid0", 32'(rvalid0), 32'd1);
        chk("t36_rdata", 32'(rdata), 32'hA5);
        chk("t36_msel", 32'(mux_select), 32'd0);

        // both held: strict alternation starting at 0
        do_reset();
        req0 = 1; req1 = 1; addr0 = 5'd3; addr1 = 5'd17;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (gnt0 || gnt1) g_seen.push_back(gnt1);
            chk("t37_onehot", 32'(gnt0 & gnt1), 32'd0);
        end
        chk("t37_ngrant", 32'(g_seen.size()), 32'd4);
        for (int i = 0; i < g_seen.size(); i++)
            chk("t37_order", 32'(g_seen[i]), 32'(i % 2));
        req0 = 0; req1 = 0;
        cycle(); cycle();

        // pointer moves to 1, lone req1 at address 17
        do_reset();
        req0 = 1; addr0 = 5'd3;
        cycle();
        req0 = 0;
        cycle(); cycle();
        req1 = 1; addr1 = 5'd17;
        cycle();
        chk("t38_gnt1", 32'(gnt1), 32'd1);
        chk("t38_msel_issue", 32'(mux_select), 32'd1);
        req1 = 0;
        cycle();
        chk("t38_msel_resp", 32'(mux_select), 32'd1);
        cycle();
        chk("t38_rvalid1", 32'(rvalid1), 32'd1);
        chk("t38_rdata", 32'(rdata), 32'h3C);

        // req1 pulsed only while busy is never granted
        req0 = 1; addr0 = 5'd9;
        cycle();
        req0 = 0; req1 = 1;
        cycle();
        req1 = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t39_no_gnt1", 32'(gnt1 | rvalid1), 32'd0);
        end

        // reset during RESP aborts, then a fresh request is served
        req0 = 1; addr0 = 5'd3;
        cycle();
        req0 = 0;
        cycle();
        chk("t40_in_resp", 32'(busy), 32'd1);
        do_reset();
        chk("t40_no_rvalid", 32'(rvalid0 | rvalid1), 32'd0);
        req0 = 1; addr0 = 5'd9;
        cycle();
        req0 = 0;
        cycle(); cycle();
        chk("t40_rdata", 32'(rdata), 32'h5A);

        // address change during RESP does not disturb the read
        req0 = 1; addr0 = 5'd3;
        cycle();
        req0 = 0;
        cycle();
        addr0 = 5'd9;
        cycle();
        chk("t41_rdata", 32'(rdata), 32'hA5);

        // random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            req0 = ($urandom_range(0, 9) < 6);
            req1 = ($urandom_range(0, 9) < 6);
            if (m_phase != 1) begin
                addr0 = WS'($urandom);
                addr1 = WS'($urandom);
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
